// File: rtl/aes_pkg.sv
// Shared AES definitions: engine FSM states, state size and byte extraction.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int AES_STATE_BYTES = 16;

  // Byte 0 is the most significant byte of the 128-bit state.
  function automatic logic [7:0] get_byte(input logic [127:0] state, input int i);
    return state[127-8*i -: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup, used by the decryption round.
module inv_sbox (
  input  logic [7:0] sbin,
  output logic [7:0] sbout
);

  localparam logic [0:255][7:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign sbout = INV_TABLE[sbin];

endmodule

// File: rtl/sbox.sv
// Combinational AES forward S-box lookup.
module sbox (
  input  logic [7:0] sbin,
  output logic [7:0] sbout
);

  localparam logic [0:255][7:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sbout = FWD_TABLE[sbin];

endmodule

// File: rtl/aes_sub_bytes_serial.sv
// Serial AES SubBytes engine: BPC shared S-box lanes walk the state in place.
// Optional inverse table selected per block when SUBBYTES_INV_EN is defined.
module aes_sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef SUBBYTES_INV_EN
  ,
  input  logic         inv
`endif
);

  // BPC must be 1, 2, 4, 8 or 16 so the lanes tile the state exactly.
  localparam int NCYC = AES_STATE_BYTES / BPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  sub_state_t    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [127:0]  data, data_n, data_sub;
  logic          load;

  logic [7:0] lane_in  [BPC];
  logic [7:0] lane_fwd [BPC];
  logic [7:0] lane_out [BPC];

`ifdef SUBBYTES_INV_EN
  logic       inv_q, inv_n;
  logic [7:0] lane_inv [BPC];
`endif

  always_comb begin
    for (int j = 0; j < BPC; j++) begin
      lane_in[j] = get_byte(data, int'(cnt) * BPC + j);
    end
  end

  for (genvar g = 0; g < BPC; g++) begin : gen_lane
    sbox u_sbox (
      .sbin  (lane_in[g]),
      .sbout (lane_fwd[g])
    );
`ifdef SUBBYTES_INV_EN
    inv_sbox u_inv_sbox (
      .sbin  (lane_in[g]),
      .sbout (lane_inv[g])
    );
    assign lane_out[g] = inv_q ? lane_inv[g] : lane_fwd[g];
`else
    assign lane_out[g] = lane_fwd[g];
`endif
  end

  // Only the bytes under the current lane window are replaced.
  always_comb begin
    data_sub = data;
    for (int j = 0; j < BPC; j++) begin
      data_sub[127 - 8*(int'(cnt) * BPC + j) -: 8] = lane_out[j];
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    data_n = data;
    load   = 1'b0;
`ifdef SUBBYTES_INV_EN
    inv_n  = inv_q;
`endif
    case (st)
      IDLE: begin
        if (in_valid) load = 1'b1;
      end
      RUN: begin
        data_n = data_sub;
        if (cnt == LAST) begin
          cnt_n = '0;
          st_n  = DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
    // A transfer out of DONE can capture the next block with no IDLE bubble.
    if (load) begin
      data_n = in_state;
      cnt_n  = '0;
      st_n   = RUN;
`ifdef SUBBYTES_INV_EN
      inv_n  = inv;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      cnt  <= '0;
      data <= '0;
`ifdef SUBBYTES_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      data <= data_n;
`ifdef SUBBYTES_INV_EN
      inv_q <= inv_n;
`endif
    end
  end

  assign in_ready  = (st == IDLE) || ((st == DONE) && out_ready);
  assign out_valid = (st == DONE);
  assign out_state = data;

endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// Self-checking bench for aes_sub_bytes_serial: one instance per legal BPC on
// shared inputs; the BPC = 4 instance carries the handshake corner cases.
module tb_aes_sub_bytes_serial;

  localparam int NDUT = 5;
  localparam int MAIN = 2;

  typedef struct {
    logic [127:0] stim;
    logic [127:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic inv = 1'b0;
  logic [127:0] in_state = '0;

  logic [NDUT-1:0]        in_ready_w;
  logic [NDUT-1:0]        out_valid_w;
  logic [NDUT-1:0][127:0] out_state_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    aes_sub_bytes_serial #(.BPC(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_state  (in_state),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_state (out_state_w[g])
`ifdef SUBBYTES_INV_EN
      ,
      .inv       (inv)
`endif
    );
  end

  localparam logic [127:0] TV_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TV_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block on every instance, then checks result and latency per BPC.
  task automatic applyStimulus(input logic [127:0] stim, input logic [127:0] exp,
                               input string name, input bit flip_inv);
    int lat [NDUT];
    logic [127:0] got [NDUT];
    for (int g = 0; g < NDUT; g++) begin
      lat[g] = -1;
      got[g] = '0;
    end
    in_state = stim;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (flip_inv) inv = ~inv;
    for (int k = 1; k <= 20; k++) begin
      step();
      for (int g = 0; g < NDUT; g++) begin
        if (lat[g] < 0 && out_valid_w[g]) begin
          lat[g] = k;
          got[g] = out_state_w[g];
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("%s bpc%0d latency", name, 1 << g), 128'(lat[g]), 128'(16 >> g));
      checkOutput($sformatf("%s bpc%0d data", name, 1 << g), got[g], exp);
    end
  endtask

  initial begin
    vec_t vecs [5];
    int accepts, xfers, accept_cyc [2], xfer_cyc [2];
    logic [127:0] xfer_data [2];
    int stale;

    vecs[0] = '{stim: 128'h0, exp: {16{8'h63}}};
    vecs[1] = '{stim: TV_IN, exp: TV_OUT};
    vecs[2] = '{stim: 128'h000102030405060708090a0b0c0d0e0f,
                exp:  128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[3] = '{stim: 128'h101112131415161718191a1b1c1d1e1f,
                exp:  128'hca82c97dfa5947f0add4a2af9ca472c0};
    vecs[4] = '{stim: {16{8'hff}}, exp: {16{8'h16}}};

    #2 rst = 1'b1;
    step();
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("reset bpc%0d in_ready", 1 << g), 128'(in_ready_w[g]), 128'd1);
      checkOutput($sformatf("reset bpc%0d out_valid", 1 << g), 128'(out_valid_w[g]), 128'd0);
      checkOutput($sformatf("reset bpc%0d out_state", 1 << g), out_state_w[g], 128'h0);
    end
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].stim, vecs[v].exp, $sformatf("vec%0d", v), 1'b0);
    end

    // Consumer stall in DONE: result held, no new accept.
    out_ready = 1'b0;
    in_state  = TV_IN;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    checkOutput("stall enter out_valid", 128'(out_valid_w[MAIN]), 128'd1);
    checkOutput("stall enter data", out_state_w[MAIN], TV_OUT);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput($sformatf("stall%0d out_valid", i), 128'(out_valid_w[MAIN]), 128'd1);
      checkOutput($sformatf("stall%0d in_ready", i), 128'(in_ready_w[MAIN]), 128'd0);
      checkOutput($sformatf("stall%0d data", i), out_state_w[MAIN], TV_OUT);
    end
    out_ready = 1'b1;
    step();
    checkOutput("stall release out_valid", 128'(out_valid_w[MAIN]), 128'd0);
    checkOutput("stall release in_ready", 128'(in_ready_w[MAIN]), 128'd1);
    repeat (20) step();

    // Back-to-back: next block captured in the same cycle the previous one leaves.
    accepts = 0;
    xfers   = 0;
    accept_cyc = '{-1, -1};
    xfer_cyc   = '{-1, -1};
    xfer_data  = '{128'h0, 128'h0};
    in_state = TV_IN;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bit acc_now, xfer_now;
      acc_now  = in_ready_w[MAIN] && in_valid;
      xfer_now = out_valid_w[MAIN] && out_ready;
      if (xfer_now && xfers < 2) begin
        xfer_cyc[xfers]  = cyc;
        xfer_data[xfers] = out_state_w[MAIN];
        xfers++;
      end
      step();
      if (acc_now && accepts < 2) begin
        accept_cyc[accepts] = cyc;
        accepts++;
        if (accepts == 1) in_state = vecs[2].stim;
        else              in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b transfers", 128'(xfers), 128'd2);
    checkOutput("b2b accept2 cycle", 128'(accept_cyc[1]), 128'(xfer_cyc[0]));
    checkOutput("b2b spacing", 128'(xfer_cyc[1] - xfer_cyc[0]), 128'd5);
    checkOutput("b2b first latency", 128'(xfer_cyc[0] - accept_cyc[0]), 128'd5);
    checkOutput("b2b data0", xfer_data[0], TV_OUT);
    checkOutput("b2b data1", xfer_data[1], vecs[2].exp);
    repeat (20) step();

    // Reset in the second RUN cycle discards the block in flight.
    in_state = TV_IN;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checkOutput("midrun rst out_valid", 128'(out_valid_w[MAIN]), 128'd0);
    checkOutput("midrun rst in_ready", 128'(in_ready_w[MAIN]), 128'd1);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("midrun rst bpc%0d out_state", 1 << g), out_state_w[g], 128'h0);
    end
    step();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid_w != '0) stale++;
    end
    checkOutput("midrun no stale result", 128'(stale), 128'd0);
    applyStimulus(vecs[3].stim, vecs[3].exp, "after rst", 1'b0);

`ifdef SUBBYTES_INV_EN
    inv = 1'b1;
    applyStimulus(TV_OUT, TV_IN, "inv", 1'b0);
    inv = 1'b1;
    applyStimulus(TV_OUT, TV_IN, "inv toggled", 1'b1);
    inv = 1'b0;
    applyStimulus(TV_IN, TV_OUT, "fwd after inv", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
